// File: rtl/pipe_step_ctrl.sv
// Debug execution controller: drives the shared pipeline clock-enable for run/stop/step/N-step.
// Optional halt-on-WB detection is compiled in with `define PIPE_STEP_HALT_DETECT_EN.
module pipe_step_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [5:0]       opcode_wb,
    output logic             db_ena,
    output logic             busy,
    output logic             halted,
    output logic             done,
    output logic             cmd_err,
    output logic [31:0]      cycle_count
);

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_STEPN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             db_ena_q, db_ena_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      cc_q, cc_d;
    logic             halt_hit_c;
    logic             is_stop_c;

`ifdef PIPE_STEP_HALT_DETECT_EN
    logic halted_q;

    // HALT is only seen when the pipeline actually advanced it into WB
    assign halt_hit_c = db_ena_q && (opcode_wb == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= (state_d == S_HALTED);
    end

    assign halted = halted_q;
`else
    logic unused_opcode_c;

    assign unused_opcode_c = ^{opcode_wb, HALT_OPCODE};
    assign halt_hit_c      = 1'b0;
    assign halted          = 1'b0;
`endif

    assign is_stop_c = cmd_valid && (cmd_op == OP_STOP);

    // Next-state: halt > STOP > step completion; illegal commands pulse cmd_err
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cc_d    = db_ena_q ? cc_q + 32'd1 : cc_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN:  state_d = S_RUN;
                        OP_STEP: begin
                            state_d = S_STEP;
                            rem_d   = CNT_W'(1);
                        end
                        OP_STEPN: begin
                            if (cmd_count == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_STEP;
                                rem_d   = cmd_count;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (halt_hit_c)     state_d = S_HALTED;
                else if (is_stop_c) state_d = S_IDLE;
                else if (cmd_valid) err_d   = 1'b1;
            end
            S_STEP: begin
                rem_d = rem_q - CNT_W'(1);
                if (halt_hit_c) begin
                    state_d = S_HALTED;
                    rem_d   = '0;
                end else if (is_stop_c) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else begin
                    if (cmd_valid) err_d = 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (is_stop_c)      state_d = S_IDLE;
                else if (cmd_valid) err_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        db_ena_d = (state_d == S_RUN) || (state_d == S_STEP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            db_ena_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cc_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            db_ena_q <= db_ena_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cc_q     <= cc_d;
        end
    end

    // busy is high exactly when the enable is, so both share one flop
    assign db_ena      = db_ena_q;
    assign busy        = db_ena_q;
    assign done        = done_q;
    assign cmd_err     = err_q;
    assign cycle_count = cc_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Scoreboard bench for pipe_step_ctrl: driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_step_ctrl;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_STEPN = 2'b11;
    localparam logic [5:0] HALT     = 6'b111111;

    // flag order: {db_ena, busy, halted, done, cmd_err}
    localparam logic [4:0] F_IDLE = 5'b00000;
    localparam logic [4:0] F_ACT  = 5'b11000;
    localparam logic [4:0] F_HLT  = 5'b00100;
    localparam logic [4:0] F_DONE = 5'b00010;
    localparam logic [4:0] F_ERR  = 5'b00001;

`ifdef PIPE_STEP_HALT_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] cc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic [5:0]  opcode_wb;
    logic        db_ena, busy, halted, done, cmd_err;
    logic [31:0] cycle_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    exp_t  m_exp, m_act;
    string m_name;

    pipe_step_ctrl #(.CNT_W(16), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .opcode_wb(opcode_wb), .db_ena(db_ena), .busy(busy),
        .halted(halted), .done(done), .cmd_err(cmd_err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per driven cycle, checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = {db_ena, busy, halted, done, cmd_err, cycle_count};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got ena/busy/halt/done/err=%b cc=%0d, want %b cc=%0d",
                         m_name, m_act.flags, m_act.cc, m_exp.flags, m_exp.cc);
            end
        end
    end

    task automatic cyc(input logic rst, input logic v, input logic [1:0] op,
                       input logic [15:0] cnt, input logic [5:0] opc,
                       input logic [4:0] flags, input logic [31:0] cc, input string n);
        reset     = rst;
        cmd_valid = v;
        cmd_op    = op;
        cmd_count = cnt;
        opcode_wb = opc;
        exp_q.push_back({flags, cc});
        name_q.push_back(n);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got no completion, want completion before 100000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_STOP; cmd_count = 16'd0; opcode_wb = 6'd0;
        #1;
        cyc(1, 0, OP_STOP, 0, 0, F_IDLE, 0, "reset0");
        cyc(1, 0, OP_STOP, 0, 0, F_IDLE, 0, "reset1");

        // STEP_N 3
        cyc(0, 1, OP_STEPN, 3, 0, F_ACT, 0, "stepn3_acc");
        cyc(0, 0, OP_STOP, 0, 0, F_ACT, 1, "stepn3_c1");
        cyc(0, 0, OP_STOP, 0, 0, F_ACT, 2, "stepn3_c2");
        cyc(0, 0, OP_STOP, 0, 0, F_DONE, 3, "stepn3_done");
        cyc(0, 0, OP_STOP, 0, 0, F_IDLE, 3, "stepn3_after");

        // RUN then STOP 10 cycles later
        cyc(0, 1, OP_RUN, 0, 0, F_ACT, 3, "run_acc");
        for (int i = 1; i <= 9; i++)
            cyc(0, 0, OP_STOP, 0, 0, F_ACT, 32'(3 + i), $sformatf("run_c%0d", i));
        cyc(0, 1, OP_STOP, 0, 0, F_IDLE, 13, "run_stop");
        cyc(0, 0, OP_STOP, 0, 0, F_IDLE, 13, "run_after");

        // STEP_N 0 completes immediately
        cyc(0, 1, OP_STEPN, 0, 0, F_DONE, 13, "stepn0");
        cyc(0, 0, OP_STOP, 0, 0, F_IDLE, 13, "stepn0_after");

        // RUN during STEP_N 2 is dropped without disturbing the count
        cyc(0, 1, OP_STEPN, 2, 0, F_ACT, 13, "stepn2_acc");
        cyc(0, 1, OP_RUN, 0, 0, F_ACT | F_ERR, 14, "stepn2_run_err");
        cyc(0, 0, OP_STOP, 0, 0, F_DONE, 15, "stepn2_done");
        cyc(0, 1, OP_STOP, 0, 0, F_IDLE, 15, "idle_stop_noop");

        // HALT reaches WB on run cycle 5
        cyc(0, 1, OP_RUN, 0, 0, F_ACT, 15, "hrun_acc");
        for (int i = 1; i <= 4; i++)
            cyc(0, 0, OP_STOP, 0, 0, F_ACT, 32'(15 + i), $sformatf("hrun_c%0d", i));
        cyc(0, 0, OP_STOP, 0, HALT, HD ? F_HLT : F_ACT, 20, "hrun_halt");
        cyc(0, 1, OP_RUN, 0, 0, HD ? (F_HLT | F_ERR) : (F_ACT | F_ERR), HD ? 32'd20 : 32'd21,
            "hrun_run_err");
        cyc(0, 1, OP_STOP, 0, 0, F_IDLE, HD ? 32'd20 : 32'd22, "hrun_stop");

        // HALT on the last step of STEP_N 4
        cyc(1, 0, OP_STOP, 0, 0, F_IDLE, 0, "reset2");
        cyc(0, 1, OP_STEPN, 4, 0, F_ACT, 0, "hstep_acc");
        for (int i = 1; i <= 3; i++)
            cyc(0, 0, OP_STOP, 0, 0, F_ACT, 32'(i), $sformatf("hstep_c%0d", i));
        cyc(0, 0, OP_STOP, 0, HALT, HD ? F_HLT : F_DONE, 4, "hstep_last");
        cyc(0, 1, OP_STOP, 0, 0, F_IDLE, 4, "hstep_stop");

        // Reset in the middle of STEP_N 100, then a single STEP
        cyc(0, 1, OP_STEPN, 100, 0, F_ACT, 4, "s100_acc");
        for (int i = 1; i <= 5; i++)
            cyc(0, 0, OP_STOP, 0, 0, F_ACT, 32'(4 + i), $sformatf("s100_c%0d", i));
        cyc(1, 0, OP_STOP, 0, 0, F_IDLE, 0, "s100_reset");
        cyc(0, 1, OP_STEP, 0, 0, F_ACT, 0, "step1_acc");
        cyc(0, 0, OP_STOP, 0, 0, F_DONE, 1, "step1_done");
        cyc(0, 0, OP_STOP, 0, 0, F_IDLE, 1, "step1_after");

        // STOP during STEP_N discards remaining steps without done
        cyc(0, 1, OP_STEPN, 5, 0, F_ACT, 1, "s5_acc");
        cyc(0, 1, OP_STEPN, 7, 0, F_ACT | F_ERR, 2, "s5_stepn_err");
        cyc(0, 1, OP_STOP, 0, 0, F_IDLE, 3, "s5_stop");
        cyc(0, 0, OP_STOP, 0, 0, F_IDLE, 3, "s5_after");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_step_ctrl.md
# pipe_step_ctrl

Debug-side execution controller that sequences the pipeline registers (IF/ID through MEM/WB) by generating their shared clock-enable `db_ena`. It accepts run, stop, single-step and N-step commands from the debug unit, watches the opcode leaving MEM/WB, and freezes the pipeline when a HALT instruction reaches write-back. It sits between the debug unit's command interface and every pipeline register's `db_ena` input.

## Interface
- `CNT_W`, 16: width of the N-step count.
- `HALT_OPCODE`, 6'b111111: opcode that freezes the pipeline when it reaches WB.
- `clk` in 1: clock. Posedge logic here; pipeline registers sample `db_ena` on negedge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command strobe, one command per cycle.
- `cmd_op` in 2: 00 STOP, 01 RUN, 10 STEP (one cycle), 11 STEP_N.
- `cmd_count` in CNT_W: step count for STEP_N, sampled with `cmd_valid`.
- `opcode_wb` in 6: opcode currently held in the MEM/WB register.
- `db_ena` out 1: pipeline clock-enable, registered.
- `busy` out 1: high in RUN or STEP.
- `halted` out 1: high in HALTED.
- `done` out 1: one-cycle pulse when a STEP/STEP_N finishes normally.
- `cmd_err` out 1: one-cycle pulse when a command is dropped.
- `cycle_count` out 32: number of enabled cycles since reset, wraps.

## Operation
- States: IDLE, RUN, STEP, HALTED. Reset → IDLE, `db_ena`=0, `busy`=0, `halted`=0, `done`=0, `cmd_err`=0, `cycle_count`=0, step counter `rem`=0.
- Commands are always accepted (no ready); illegal ones are dropped with a `cmd_err` pulse.
- IDLE:
  - RUN → RUN.
  - STEP → STEP with `rem`=1.
  - STEP_N with `cmd_count`≥1 → STEP with `rem`=`cmd_count`.
  - STEP_N with `cmd_count`=0 → stay IDLE, `done` pulses.
  - STOP → no-op.
- RUN: `db_ena`=1 every cycle.
  - STOP → IDLE.
  - RUN, STEP or STEP_N → dropped, `cmd_err`.
- STEP: `db_ena`=1. Each edge with `db_ena`=1 decrements `rem`.
  - When `rem`=1 at such an edge → IDLE, `done`=1.
  - STOP → IDLE with no `done`; remaining steps are discarded.
  - Other commands → `cmd_err`.
- Halt detect: at an edge where `db_ena`=1 and `opcode_wb`==`HALT_OPCODE` in RUN or STEP → HALTED.
- HALTED: `db_ena`=0.
  - STOP → IDLE, clearing `halted`.
  - Other commands → `cmd_err`.
- Priority at one edge: reset > halt detect > STOP > step-count completion. Halt on the last step: go to HALTED, no `done`.
- `cycle_count` increments by 1 mod 2^32 at every edge where `db_ena`=1.

## Timing
- Command accepted at posedge k: `db_ena` rises after edge k.
  - The first pipeline advance is the negedge within cycle k.
- STEP_N with N: `db_ena` is high for exactly N cycles (after edges k..k+N-1). It is low after edge k+N, with `done` high for that one cycle.
- HALT reaches WB at the negedge in cycle j. It is sampled at posedge j+1, and `db_ena` goes low after that edge. There are zero further pipeline advances.
- STOP accepted at edge k: `db_ena` is low after edge k.
- `busy` and `halted` are registered and change on the same edge as the state.
- Reset asserted mid-RUN or mid-STEP: all outputs take their reset values after the next posedge. Any pending step count is lost.

## Configuration
- `PIPE_STEP_HALT_DETECT_EN` defined: halt detect as specified above.
- Undefined: `opcode_wb` is ignored and HALTED is unreachable. `halted` is tied to 0, and RUN continues until STOP.

## Test plan
- Reset, then STEP_N with `cmd_count`=3 → `db_ena` high exactly 3 cycles, `done` pulses once, `cycle_count`=3, state IDLE.
- RUN, then STOP 10 cycles later → `db_ena` high 10 cycles, `cycle_count`=10, `busy`=0 after the STOP edge.
- RUN with `opcode_wb` forced to 6'b111111 at cycle 5 → `db_ena` low from the next edge, `halted`=1. A following RUN gives `cmd_err`; STOP clears `halted`.
- STEP_N with `cmd_count`=0 → `done` pulses and `db_ena` stays 0. A RUN issued during STEP gives a `cmd_err` pulse and the step count is unaffected.
- HALT arriving on the last step of STEP_N 4 → HALTED, no `done` pulse, `cycle_count`=4.
- Reset asserted in the middle of STEP_N 100 → after the edge, `db_ena`=0, `cycle_count`=0, IDLE. A following STEP yields exactly 1 enabled cycle.
